// File: rtl/mmio_bridge_if.sv
// ----------------------------------------------------------------------------
// mmio_bridge_if
//   Bundles every bus signal that touches mmio_bridge. The three groups are the
//   CPU MEM-stage data port, the data-memory port and the TX byte stream.
//   Clock and reset are not in the bundle. They stay plain module ports.
//
//   CPU side     : memwrite, memaddr, memwritedata (to bridge), memreaddata (from bridge)
//   Data memory  : dmem_we, dmem_addr, dmem_wdata (from bridge), dmem_rdata (to bridge)
//   TX stream    : tx_valid, tx_data (from bridge), tx_ready (to bridge)
//   Interrupt    : irq (from bridge)
//
//   Modports
//     master : the system/CPU side that drives requests and consumes results
//     slave  : the bridge itself
// ----------------------------------------------------------------------------
interface mmio_bridge_if;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        irq;

  modport master (
    output memwrite, memaddr, memwritedata, dmem_rdata, tx_ready,
    input  memreaddata, dmem_we, dmem_addr, dmem_wdata, tx_valid, tx_data, irq
  );

  modport slave (
    input  memwrite, memaddr, memwritedata, dmem_rdata, tx_ready,
    output memreaddata, dmem_we, dmem_addr, dmem_wdata, tx_valid, tx_data, irq
  );
endinterface

// File: rtl/mmio_bridge.sv
// ----------------------------------------------------------------------------
// mmio_bridge
//   Sits behind the CPU MEM-stage data port. Each access goes to one of two
//   places:
//     - data memory (straight pass-through), or
//     - a 16-byte peripheral window at MMIO_BASE. The window holds a byte TX
//       FIFO and a 32-bit down-counting timer.
//   Peripheral reads are combinational, so the CPU captures them in the same
//   MEM cycle. Register writes land on the clock edge that ends the MEM cycle.
//
//   Register map (offset from MMIO_BASE, addr[1:0] ignored)
//     0x0 TXDATA  W: push byte      R: {24'b0, head byte}
//     0x4 STATUS  W: clear ovf      R: {16'b0, count[7:0], 4'b0, ovf, expired, empty, full}
//     0x8 TLOAD   W: load+count     R: current count
//     0xC TCTRL   W: en/autoreload/clear-expired/irq_en
//                 R: {28'b0, irq_en, 1'b0, autoreload, en}
//
//   Ports
//     clk    : system clock, all state on the rising edge
//     reset  : asynchronous, active-high
//     bus    : mmio_bridge_if.slave (CPU port, data-memory port, TX stream, irq)
//
//   Parameters
//     FIFO_DEPTH : TX FIFO entries, power of two, 2..256
//     MMIO_BASE  : base of the peripheral window; only bits [31:4] are compared
//
//   Build option
//     MMIO_TIMER_IRQ_EN : when defined, irq = expired & irq_en and TCTRL bit3 is
//                         a real register bit. When undefined, irq is tied low
//                         and TCTRL bit3 is neither stored nor read back.
// ----------------------------------------------------------------------------
module mmio_bridge #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFFFF00
) (
  input  logic         clk,
  input  logic         reset,
  mmio_bridge_if.slave bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_TLOAD  = 2'd2,
    REG_TCTRL  = 2'd3
  } regSel_e;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic    sel;
  regSel_e regOff;
  logic    regWr;
  logic    pushReq;
  logic    statusWr;
  logic    tloadWr;
  logic    tctrlWr;

  assign sel      = (bus.memaddr[31:4] == MMIO_BASE[31:4]);
  assign regOff   = regSel_e'(bus.memaddr[3:2]);
  assign regWr    = bus.memwrite & sel;
  assign pushReq  = regWr & (regOff == REG_TXDATA);
  assign statusWr = regWr & (regOff == REG_STATUS);
  assign tloadWr  = regWr & (regOff == REG_TLOAD);
  assign tctrlWr  = regWr & (regOff == REG_TCTRL);

  // Stores that miss the window go through to data memory unchanged.
  assign bus.dmem_we    = bus.memwrite & ~sel;
  assign bus.dmem_addr  = bus.memaddr;
  assign bus.dmem_wdata = bus.memwritedata;

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [7:0]    fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full;
  logic          empty;
  logic          pushOk;
  logic          pop;
  logic [7:0]    headByte;
  logic [7:0]    count8;

  // Fullness is judged on the pre-edge count. A pop in the same cycle does
  // not make room for a push into a full FIFO.
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pushOk   = pushReq & ~full;
  assign pop      = ~empty & bus.tx_ready;
  assign headByte = fifoMem_q[rdPtr_q];

  assign bus.tx_valid = ~empty;
  assign bus.tx_data  = headByte;

  // Pointer, occupancy and sticky-overflow next state. Pointers are exactly
  // log2(depth) bits wide, so they wrap on their own. A push drops its byte
  // and sets ovf when the FIFO is full. A STATUS write clears ovf.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (pushOk) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end

    case ({pushOk, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pushReq & full) begin
      ovf_d = 1'b1;
    end else if (statusWr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is cleared on reset. This makes tx_data read 8'h00 until the
  // first push, instead of stale contents from before the reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifoMem_q[i] <= 8'h00;
      end
    end else if (pushOk) begin
      fifoMem_q[wrPtr_q] <= bus.memwritedata[7:0];
    end
  end

  // STATUS reports only the low byte of the occupancy count. A full
  // 256-deep FIFO therefore reads as 0 there, but the full flag is still set.
  generate
    if (CW > 8) begin : gCountWide
      assign count8 = count_q[7:0];
    end else begin : gCountNarrow
      assign count8 = 8'(count_q);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Timer
  // --------------------------------------------------------------------------
  logic [31:0] load_q, load_d;
  logic [31:0] tcount_q, tcount_d;
  logic        en_q, en_d;
  logic        autoReload_q, autoReload_d;
  logic        expired_q, expired_d;
  logic        expire;
  logic        irqEnRd;

  // Timer next state, in priority order:
  //   1. A TLOAD write reloads load and count. It overrides any decrement
  //      or reload in the same cycle.
  //   2. When enabled, a nonzero count decrements.
  //   3. When enabled, a zero count either reloads (autoreload) or holds.
  // A count of 0 is only reached one cycle after the 1->0 step. The reload
  // therefore lands one cycle later and the count shows 0 for exactly one
  // cycle. If an expiry and a clear of expired happen together, the expiry
  // wins, so an interrupt is never lost.
  always_comb begin
    load_d       = load_q;
    tcount_d     = tcount_q;
    en_d         = en_q;
    autoReload_d = autoReload_q;
    expired_d    = expired_q;
    expire       = 1'b0;

    if (tloadWr) begin
      load_d   = bus.memwritedata;
      tcount_d = bus.memwritedata;
    end else if (en_q) begin
      if (tcount_q != 32'd0) begin
        tcount_d = tcount_q - 32'd1;
        expire   = (tcount_q == 32'd1);
      end else if (autoReload_q) begin
        tcount_d = load_q;
      end
    end

    if (tctrlWr) begin
      en_d         = bus.memwritedata[0];
      autoReload_d = bus.memwritedata[1];
    end

    if (expire) begin
      expired_d = 1'b1;
    end else if (tctrlWr & bus.memwritedata[2]) begin
      expired_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q       <= 32'd0;
      tcount_q     <= 32'd0;
      en_q         <= 1'b0;
      autoReload_q <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      load_q       <= load_d;
      tcount_q     <= tcount_d;
      en_q         <= en_d;
      autoReload_q <= autoReload_d;
      expired_q    <= expired_d;
    end
  end

`ifdef MMIO_TIMER_IRQ_EN
  // Interrupt enable flop. irq is built only from registered bits, so it
  // cannot glitch on bus activity.
  logic irqEn_q, irqEn_d;

  always_comb begin
    irqEn_d = irqEn_q;
    if (tctrlWr) begin
      irqEn_d = bus.memwritedata[3];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqEn_q <= 1'b0;
    end else begin
      irqEn_q <= irqEn_d;
    end
  end

  assign irqEnRd = irqEn_q;
  assign bus.irq = expired_q & irqEn_q;
`else
  assign irqEnRd = 1'b0;
  assign bus.irq = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  logic [31:0] regRdata;

  // Register read mux. It is combinational so the CPU sees the value in the
  // same MEM cycle. A write and a read of the same register never collide,
  // because a store does not return data.
  always_comb begin
    regRdata = 32'd0;
    case (regOff)
      REG_TXDATA: regRdata = {24'd0, headByte};
      REG_STATUS: regRdata = {16'd0, count8, 4'd0, ovf_q, expired_q, empty, full};
      REG_TLOAD:  regRdata = tcount_q;
      REG_TCTRL:  regRdata = {28'd0, irqEnRd, 1'b0, autoReload_q, en_q};
      default:    regRdata = 32'd0;
    endcase
  end

  assign bus.memreaddata = sel ? regRdata : bus.dmem_rdata;

endmodule

// File: tb/tb_mmio_bridge.sv
// ----------------------------------------------------------------------------
// tb_mmio_bridge
//   Self-checking bench for mmio_bridge.
//   Reference model:
//     - the FIFO is a byte queue,
//     - the timer is a handful of plain integers,
//     - the model steps on every rising edge and clears on reset.
//   On every falling edge, a compare process checks each DUT output against
//   the model. Directed sequences first exercise reset, pass-through,
//   overflow, simultaneous push/pop and the timer. Those sequences carry
//   hand-computed literal expectations. A randomized run follows, including
//   an asynchronous reset mid-run.
// ----------------------------------------------------------------------------
module tb_mmio_bridge;

  localparam int unsigned DEPTH    = 8;
  localparam logic [31:0] BASE     = 32'hFFFFFF00;
  localparam logic [31:0] A_TXDATA = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_TLOAD  = BASE + 32'h8;
  localparam logic [31:0] A_TCTRL  = BASE + 32'hC;
  localparam logic [31:0] A_RAM    = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_bridge_if bus();

  mmio_bridge #(.FIFO_DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  byte unsigned fq[$];
  bit           mOvf, mExp, mEn, mAr, mIe, mPushed;
  logic [31:0]  mLoad, mCnt;

  always @(posedge clk or posedge reset) begin : model
    bit          isSel, wr, setExp;
    logic [1:0]  off;
    int unsigned sz;
    if (reset) begin
      fq.delete();
      mOvf = 0; mExp = 0; mEn = 0; mAr = 0; mIe = 0; mPushed = 0;
      mLoad = 0; mCnt = 0;
    end else begin
      isSel = (bus.memaddr[31:4] == BASE[31:4]);
      off   = bus.memaddr[3:2];
      wr    = bus.memwrite && isSel;
      sz    = fq.size();
      if (bus.tx_ready && sz > 0) void'(fq.pop_front());
      if (wr && off == 2'd0) begin
        if (sz < DEPTH) begin
          fq.push_back(bus.memwritedata[7:0]);
          mPushed = 1;
        end else begin
          mOvf = 1;
        end
      end
      if (wr && off == 2'd1) mOvf = 0;
      setExp = 0;
      if (wr && off == 2'd2) begin
        mLoad = bus.memwritedata;
        mCnt  = bus.memwritedata;
      end else if (mEn) begin
        if (mCnt != 0) begin
          mCnt = mCnt - 1;
          if (mCnt == 0) setExp = 1;
        end else if (mAr) begin
          mCnt = mLoad;
        end
      end
      if (wr && off == 2'd3) begin
        if (bus.memwritedata[2]) mExp = 0;
        mEn = bus.memwritedata[0];
        mAr = bus.memwritedata[1];
`ifdef MMIO_TIMER_IRQ_EN
        mIe = bus.memwritedata[3];
`endif
      end
      if (setExp) mExp = 1;
    end
  end

  function automatic logic [31:0] modelRead(input logic [1:0] off);
    logic [7:0] head;
    head = (fq.size() > 0) ? fq[0] : 8'h00;
    case (off)
      2'd0:    return {24'h0, head};
      2'd1:    return {16'h0, 8'(fq.size()), 4'h0, mOvf, mExp, (fq.size() == 0), (fq.size() == DEPTH)};
      2'd2:    return mCnt;
      default: return {28'h0, mIe, 1'b0, mAr, mEn};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic       isSel;
    logic [1:0] off;
    bit         headKnown;
    isSel     = (bus.memaddr[31:4] == BASE[31:4]);
    off       = bus.memaddr[3:2];
    headKnown = (fq.size() > 0) || !mPushed;
    checkOutput("dmem_we", 32'(bus.dmem_we), 32'(bus.memwrite && !isSel));
    checkOutput("dmem_addr", bus.dmem_addr, bus.memaddr);
    checkOutput("dmem_wdata", bus.dmem_wdata, bus.memwritedata);
    checkOutput("tx_valid", 32'(bus.tx_valid), 32'(fq.size() > 0));
    if (headKnown) checkOutput("tx_data", 32'(bus.tx_data), modelRead(2'd0));
    if (!isSel) begin
      checkOutput("rdata_dmem", bus.memreaddata, bus.dmem_rdata);
    end else if (off != 2'd0 || headKnown) begin
      checkOutput("rdata_mmio", bus.memreaddata, modelRead(off));
    end
`ifdef MMIO_TIMER_IRQ_EN
    checkOutput("irq", 32'(bus.irq), 32'(mExp && mIe));
`else
    checkOutput("irq", 32'(bus.irq), 32'd0);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bus.memwrite     = w;
    bus.memaddr      = a;
    bus.memwritedata = d;
    bus.tx_ready     = rdy;
    bus.dmem_rdata   = $urandom;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tseq [5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
  int unsigned rdyBias;

  initial begin
    reset = 1'b0;
    bus.memwrite = 0; bus.memaddr = A_RAM; bus.memwritedata = 0;
    bus.dmem_rdata = 0; bus.tx_ready = 0;
    #2 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset values
    applyStimulus(0, A_STATUS, 0, 0);
    checkOutput("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(bus.tx_data), 32'd0);
    checkOutput("rst_irq", 32'(bus.irq), 32'd0);
    checkOutput("rst_status", bus.memreaddata, 32'h0000_0002);
    tick();

    // Data-memory pass-through and near-miss window boundaries
    applyStimulus(1, 32'h10, 32'h55, 0);
    checkOutput("pt_we", 32'(bus.dmem_we), 32'd1);
    checkOutput("pt_addr", bus.dmem_addr, 32'h10);
    checkOutput("pt_wdata", bus.dmem_wdata, 32'h55);
    tick();
    applyStimulus(0, 32'h10, 0, 0);
    bus.dmem_rdata = 32'hCAFE_F00D; #1;
    checkOutput("pt_load", bus.memreaddata, 32'hCAFE_F00D);
    tick();
    applyStimulus(1, 32'hFFFF_FEFC, 32'h1, 0);
    checkOutput("below_win_we", 32'(bus.dmem_we), 32'd1);
    tick();
    applyStimulus(1, A_TXDATA + 32'h3, 32'hAB, 0);
    checkOutput("in_win_we", 32'(bus.dmem_we), 32'd0);
    tick();
    applyStimulus(0, A_RAM, 0, 1); tick();   // drain the 0xAB byte

    // Overflow: push 9 bytes into an 8-deep FIFO, then drain in order
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1, A_TXDATA, 32'(i), 0); tick();
    end
    applyStimulus(0, A_STATUS, 0, 0);
    checkOutput("ovf_status", bus.memreaddata, 32'h0000_0809);
    checkOutput("ovf_head", 32'(bus.tx_data), 32'h01);
    tick();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, A_RAM, 0, 1);
      checkOutput("drain_valid", 32'(bus.tx_valid), 32'd1);
      checkOutput("drain_data", 32'(bus.tx_data), 32'(i));
      tick();
    end
    applyStimulus(0, A_STATUS, 0, 0);
    checkOutput("drained_valid", 32'(bus.tx_valid), 32'd0);
    checkOutput("drained_status", bus.memreaddata, 32'h0000_000A);
    tick();
    applyStimulus(1, A_STATUS, 32'h0, 0); tick();

    // Simultaneous push and pop with two entries held
    applyStimulus(1, A_TXDATA, 32'hA1, 0); tick();
    applyStimulus(1, A_TXDATA, 32'hA2, 0); tick();
    applyStimulus(1, A_TXDATA, 32'hA3, 1);
    checkOutput("pp_head", 32'(bus.tx_data), 32'hA1);
    tick();
    applyStimulus(0, A_STATUS, 0, 0);
    checkOutput("pp_status", bus.memreaddata, 32'h0000_0200);
    tick();
    applyStimulus(0, A_RAM, 0, 1);
    checkOutput("pp_b", 32'(bus.tx_data), 32'hA2);
    tick();
    applyStimulus(0, A_RAM, 0, 1);
    checkOutput("pp_c", 32'(bus.tx_data), 32'hA3);
    tick();

    // Full FIFO: a pop in the same cycle does not make room for the push
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, A_TXDATA, 32'h10 + 32'(i), 0); tick();
    end
    applyStimulus(1, A_TXDATA, 32'h99, 1);
    checkOutput("fp_head", 32'(bus.tx_data), 32'h10);
    tick();
    applyStimulus(0, A_STATUS, 0, 0);
    checkOutput("fp_status", bus.memreaddata, 32'h0000_0708);
    tick();
    for (int i = 1; i < 8; i++) begin
      applyStimulus(0, A_RAM, 0, 1);
      checkOutput("fp_drain", 32'(bus.tx_data), 32'h10 + 32'(i));
      tick();
    end
    applyStimulus(1, A_STATUS, 0, 0);
    checkOutput("fp_empty", 32'(bus.tx_valid), 32'd0);
    tick();

    // Timer with autoreload; expired set wins over a same-cycle clear
    applyStimulus(1, A_TLOAD, 32'd3, 0); tick();
    applyStimulus(1, A_TCTRL, 32'h3, 0); tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, A_TLOAD, 0, 0);
      checkOutput("tmr_seq", bus.memreaddata, tseq[k]);
      tick();
    end
    applyStimulus(0, A_STATUS, 0, 0);
    checkOutput("tmr_expired", bus.memreaddata, 32'h0000_0006);
    tick();
    applyStimulus(1, A_TCTRL, 32'h7, 0); tick();
    applyStimulus(0, A_STATUS, 0, 0);
    checkOutput("tmr_set_wins", bus.memreaddata, 32'h0000_0006);
    tick();
    applyStimulus(1, A_TCTRL, 32'h7, 0); tick();
    applyStimulus(0, A_STATUS, 0, 0);
    checkOutput("tmr_cleared", bus.memreaddata, 32'h0000_0002);
    tick();
    applyStimulus(1, A_TCTRL, 32'hB, 0); tick();
    applyStimulus(0, A_TCTRL, 0, 0);
`ifdef MMIO_TIMER_IRQ_EN
    checkOutput("irq_on", 32'(bus.irq), 32'd1);
    checkOutput("tctrl_rd", bus.memreaddata, 32'h0000_000B);
`else
    checkOutput("irq_off", 32'(bus.irq), 32'd0);
    checkOutput("tctrl_rd", bus.memreaddata, 32'h0000_0003);
`endif
    tick();
    applyStimulus(1, A_TCTRL, 32'h4, 0); tick();
    applyStimulus(0, A_TLOAD, 0, 0);
    checkOutput("tmr_stop_irq", 32'(bus.irq), 32'd0);
    checkOutput("tmr_stop_cnt", bus.memreaddata, 32'd2);
    tick();
    applyStimulus(0, A_TLOAD, 0, 0);
    checkOutput("tmr_hold_cnt", bus.memreaddata, 32'd2);
    tick();

    // Asynchronous reset mid-run: FIFO count 3, timer counting
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, A_TXDATA, 32'h31 + 32'(i), 0); tick();
    end
    applyStimulus(1, A_TLOAD, 32'd100, 0); tick();
    applyStimulus(1, A_TCTRL, 32'hB, 0); tick();
    applyStimulus(0, A_STATUS, 0, 0);
    checkOutput("pre_rst_status", bus.memreaddata, 32'h0000_0300);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
    checkOutput("mid_rst_data", 32'(bus.tx_data), 32'd0);
    checkOutput("mid_rst_irq", 32'(bus.irq), 32'd0);
    checkOutput("mid_rst_we", 32'(bus.dmem_we), 32'd0);
    checkOutput("mid_rst_status", bus.memreaddata, 32'h0000_0002);
    tick();
    reset = 1'b0;
    applyStimulus(0, A_TCTRL, 0, 0);
    checkOutput("post_rst_tctrl", bus.memreaddata, 32'd0);
    tick();
    applyStimulus(0, A_TLOAD, 0, 0);
    checkOutput("post_rst_tload", bus.memreaddata, 32'd0);
    tick();

    // Randomized traffic checked by the compare process
    rdyBias = 2;
    for (int n = 0; n < 2500; n++) begin
      int unsigned pick;
      logic [31:0] a, d;
      logic w, rdy;
      if (n % 250 == 0) rdyBias = $urandom_range(0, 3);
      pick = $urandom_range(0, 99);
      if (pick < 65)      a = BASE | 32'($urandom_range(0, 15));
      else if (pick < 75) a = pick[0] ? (BASE + 32'h10 + 32'($urandom_range(0, 15)))
                                      : (BASE - 32'h10 + 32'($urandom_range(0, 15)));
      else                a = $urandom & 32'h0000_FFFC;
      w = ($urandom_range(0, 1) == 1);
      d = $urandom;
      if (a[31:4] == BASE[31:4] && a[3:2] == 2'd2) d = $urandom_range(0, 12);
      if (a[31:4] == BASE[31:4] && a[3:2] == 2'd3) d = $urandom_range(0, 15);
      rdy = ($urandom_range(0, 3) < rdyBias);
      applyStimulus(w, a, d, rdy);
      if (n == 1300) begin
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    applyStimulus(0, A_RAM, 0, 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
